// File: rtl/rect_render_pkg.sv
// rtl/rect_render_pkg.sv - shared widths, state encoding and colour constants for rect_render
package rect_render_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int COLOR_W_DEF = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    localparam logic [COLOR_W_DEF-1:0] BLACK = '0;

endpackage

// File: rtl/rect_hit_cmp.sv
// rtl/rect_hit_cmp.sv - four bound comparisons plus stage-1 register of the hit pipeline
module rect_hit_cmp
    import rect_render_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               video_on,
    output logic               hit_o,
    output logic               video_on_o
);

    logic ge_x_q, lt_x_q, ge_y_q, lt_y_q, video_on_q;
    logic ge_x_d, lt_x_d, ge_y_d, lt_y_d;

    // An empty box (x2 <= x1 or y2 <= y1) can never satisfy both bounds of an axis.
    always_comb begin
        ge_x_d = (hcount >= x1);
        lt_x_d = (hcount <  x2);
        ge_y_d = (vcount >= y1);
        lt_y_d = (vcount <  y2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ge_x_q     <= 1'b0;
            lt_x_q     <= 1'b0;
            ge_y_q     <= 1'b0;
            lt_y_q     <= 1'b0;
            video_on_q <= 1'b0;
        end else begin
            ge_x_q     <= ge_x_d;
            lt_x_q     <= lt_x_d;
            ge_y_q     <= ge_y_d;
            lt_y_q     <= lt_y_d;
            video_on_q <= video_on;
        end
    end

    assign hit_o      = ge_x_q & lt_x_q & ge_y_q & lt_y_q;
    assign video_on_o = video_on_q;

endmodule

// File: rtl/rect_render.sv
// rtl/rect_render.sv - frame-synchronous rectangle capture/commit and two-stage pixel renderer
module rect_render
    import rect_render_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic               coord_valid,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               video_on,
    input  logic [COLOR_W-1:0] fg_color,
    input  logic [COLOR_W-1:0] bg_color,
    output logic [COLOR_W-1:0] rgb,
    output logic               in_rect,
    output logic               busy
);

    state_e state_q, state_d;
    logic   capture, commit;

    logic [COORD_W-1:0] pend_x1_q, pend_y1_q, pend_x2_q, pend_y2_q;
    logic [COORD_W-1:0] pend_x1_d, pend_y1_d, pend_x2_d, pend_y2_d;
    logic [COORD_W-1:0] act_x1_q, act_y1_q, act_x2_q, act_y2_q;
    logic [COORD_W-1:0] act_x1_d, act_y1_d, act_x2_d, act_y2_d;

    logic               hit_s1, video_on_s1;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               in_rect_q, in_rect_d;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A capture landing on the same edge as a commit keeps the machine armed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (coord_valid)                 state_d = ST_ARMED;
            ST_ARMED: if (frame_start && !coord_valid) state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_ARMED);
        capture = coord_valid;
        commit  = frame_start && (state_q == ST_ARMED);
    end

    always_comb begin
        pend_x1_d = pend_x1_q;
        pend_y1_d = pend_y1_q;
        pend_x2_d = pend_x2_q;
        pend_y2_d = pend_y2_q;
        if (capture) begin
            pend_x1_d = x1;
            pend_y1_d = y1;
            pend_x2_d = x2;
            pend_y2_d = y2;
        end
    end

    // Commit reads the pending registers before this edge's capture overwrites them.
    always_comb begin
        act_x1_d = act_x1_q;
        act_y1_d = act_y1_q;
        act_x2_d = act_x2_q;
        act_y2_d = act_y2_q;
        if (commit) begin
            act_x1_d = pend_x1_q;
            act_y1_d = pend_y1_q;
            act_x2_d = pend_x2_q;
            act_y2_d = pend_y2_q;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x1_q <= '0;
            pend_y1_q <= '0;
            pend_x2_q <= '0;
            pend_y2_q <= '0;
            act_x1_q  <= '0;
            act_y1_q  <= '0;
            act_x2_q  <= '0;
            act_y2_q  <= '0;
        end else begin
            pend_x1_q <= pend_x1_d;
            pend_y1_q <= pend_y1_d;
            pend_x2_q <= pend_x2_d;
            pend_y2_q <= pend_y2_d;
            act_x1_q  <= act_x1_d;
            act_y1_q  <= act_y1_d;
            act_x2_q  <= act_x2_d;
            act_y2_q  <= act_y2_d;
        end
    end

    rect_hit_cmp #(
        .COORD_W (COORD_W)
    ) u_hit (
        .clk        (pixel_clk),
        .rst_n      (rst_n),
        .x1         (act_x1_q),
        .y1         (act_y1_q),
        .x2         (act_x2_q),
        .y2         (act_y2_q),
        .hcount     (hcount),
        .vcount     (vcount),
        .video_on   (video_on),
        .hit_o      (hit_s1),
        .video_on_o (video_on_s1)
    );

    // Colours are taken live at stage 2 rather than delayed alongside the hit.
    always_comb begin
        in_rect_d = hit_s1 && video_on_s1;
        if (!video_on_s1)  rgb_d = COLOR_W'(BLACK);
        else if (hit_s1)   rgb_d = fg_color;
        else               rgb_d = bg_color;
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q     <= '0;
            in_rect_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            in_rect_q <= in_rect_d;
        end
    end

    assign rgb     = rgb_q;
    assign in_rect = in_rect_q;

endmodule

// File: doc/rect_render.md
RECT_RENDER -- requirements
Module: rect_render

Interface
REQ-001 Parameter COORD_W, default 11: width of all coordinate and counter ports.
REQ-002 Parameter COLOR_W, default 12: width of the colour ports (4:4:4 RGB).
REQ-003 Port pixel_clk, input, 1: pixel clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port x1, y1, x2, y2, input, COORD_W each: rectangle bounds from the upstream line-geometry stage; x1/y1 inclusive, x2/y2 exclusive.
REQ-006 Port coord_valid, input, 1: one-cycle strobe; x1..y2 are meaningful in that cycle.
REQ-007 Port frame_start, input, 1: one-cycle pulse from the VGA timing generator at the start of vertical blanking.
REQ-008 Port hcount, vcount, input, COORD_W each: current pixel position.
REQ-009 Port video_on, input, 1: high inside the visible area.
REQ-010 Port fg_color, bg_color, input, COLOR_W each: rectangle and background colours.
REQ-011 Port rgb, output, COLOR_W: registered pixel colour.
REQ-012 Port in_rect, output, 1: registered flag; the pixel lies inside the active rectangle.
REQ-013 Port busy, output, 1: high while a captured rectangle waits for the next frame_start.

Function
REQ-014 Capture: on coord_valid, latch x1..y2 into pending registers and set pending.
- Later coord_valid before frame_start overwrites the pending data (last wins).
REQ-015 Commit: on frame_start with pending set, copy pending to the active registers and clear pending.
- Commit occurs on the edge that samples frame_start.
- With no pending data, frame_start leaves the active registers unchanged.
REQ-016 Simultaneous coord_valid and frame_start:
- The previously pending value commits.
- The new value becomes pending.
- With nothing previously pending, the new value waits for the next frame_start.
REQ-017 State machine has two states:
- IDLE (pending clear) goes to ARMED on coord_valid.
- ARMED goes to IDLE on frame_start without a simultaneous coord_valid; otherwise it stays ARMED.
- busy is high in ARMED only.
REQ-018 Empty rectangle: when x2 <= x1 or y2 <= y1 in the active registers, in_rect stays 0 for the whole frame.
REQ-019 Hit test: hcount >= x1 AND hcount < x2 AND vcount >= y1 AND vcount < y2, as unsigned COORD_W comparisons; no wrap-around handling.
REQ-020 Pipeline, latency exactly 2 cycles from hcount/vcount/video_on to in_rect/rgb:
- Stage 1 registers the four compare results and the delayed video_on.
- Stage 2 registers the outputs.
REQ-021 rgb output:
- fg_color when the stage-1 hit is set and the delayed video_on is high.
- bg_color when not hit and video_on is high.
- All zeros when video_on is low.
REQ-022 Colour timing: fg_color and bg_color are sampled at stage 2, not delayed through the pipeline.
REQ-023 in_rect is forced 0 whenever the delayed video_on is low.

Reset
REQ-024 rst_n low asynchronously clears:
- all outputs (rgb=0, in_rect=0, busy=0);
- pipeline registers and pending flag, returning the state machine to IDLE;
- active and pending bounds to 0, which gives an empty rectangle.
REQ-025 Reset mid-frame discards any pending rectangle; no rectangle is drawn until a new capture is committed.
REQ-026 Release of rst_n takes effect on the next pixel_clk edge; no reset synchroniser is inside the block.

Structure
REQ-027 A shared package holds:
- COORD_W and COLOR_W defaults;
- the state encoding constants (IDLE=0, ARMED=1);
- the black colour constant.
REQ-028 A single sub-module rect_hit_cmp holds the four bound comparisons and the stage-1 register, for reuse when several rectangles are composited.
REQ-029 No other sub-modules.

Verification
REQ-030 Commit timing:
- Stimulus: reset, then coord_valid with (100,200,194,202), then frame_start.
- Response: busy is 1 until frame_start; at pixel (100,200) in_rect=1 two cycles later; at (194,200) and (100,202) in_rect=0.
REQ-031 Last-wins capture:
- Stimulus: two coord_valid strobes, (10,10,20,12) then (50,50,60,52), before one frame_start.
- Response: only (50..59, 50..51) hits.
REQ-032 Simultaneous events:
- Stimulus: coord_valid (300,300,310,302) in the same cycle as frame_start, with (0,0,8,2) previously pending.
- Response: (0,0) hits this frame; busy stays 1; (300,300) hits after the next frame_start.
REQ-033 Empty and blanking:
- Stimulus: commit (40,40,40,50).
- Response: in_rect=0 and rgb=bg_color across the frame; with video_on=0, rgb=0.
REQ-034 Reset mid-operation:
- Stimulus: rst_n pulsed low while ARMED and during an active hit.
- Response: rgb=0, in_rect=0 and busy=0 immediately without a clock; no hit after the following frame_start.
REQ-035 Latency check: a hit driven at cycle N appears at cycle N+2, with rgb=fg_color at that edge.
